// File: rtl/bram_lsu_master.sv
// bram_lsu_master: single-outstanding RV32I load/store initiator for BRAM port B
module bram_lsu_master #(
  parameter int MEM_DEPTH    = 1096,
  parameter int READ_LATENCY = 1
) (
  input  logic        clkb,
  input  logic        rstb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        enb,
  output logic [3:0]  web,
  output logic [31:0] addrb,
  output logic [31:0] dinb,
  input  logic [31:0] doutb,
  input  logic        rstb_busy
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_DEPTH * 4);
  state_t      state_q;
  logic        we_q, rsp_valid_q, rsp_err_q, enb_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q, cnt_q;
  logic [3:0]  web_q;
  logic [31:0] rsp_rdata_q, addrb_q, dinb_q;
  logic        accept, illegal, misaligned, out_of_range, err_d;
  logic [3:0]  web_d;
  logic [15:0] lane_d;
  logic [31:0] dinb_d, rdata_d;

  assign req_ready    = state_q == IDLE && !rstb_busy && !rstb;
  assign accept       = req_valid && req_ready;
  assign illegal      = req_we ? req_funct3 > 3'd2 : req_funct3 == 3'd3 || req_funct3 > 3'd5;
  assign misaligned   = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
  assign out_of_range = {1'b0, req_addr} >= ADDR_LIMIT;
  assign err_d        = illegal || misaligned || out_of_range;
  assign web_d  = req_funct3[1:0] == 2'd0 ? 4'b0001 << req_addr[1:0] :
                  req_funct3[1:0] == 2'd1 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign dinb_d = req_funct3[1:0] == 2'd0 ? {4{req_wdata[7:0]}} :
                  req_funct3[1:0] == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
  // low byte of lane_d is the addressed byte; for halves lo_q[0] is always 0
  assign lane_d  = lo_q[1] ? (lo_q[0] ? {8'h00, doutb[31:24]} : doutb[31:16])
                           : (lo_q[0] ? doutb[23:8] : doutb[15:0]);
  assign rdata_d = f3_q[1:0] == 2'd0 ? {{24{lane_d[7] & !f3_q[2]}}, lane_d[7:0]} :
                   f3_q[1:0] == 2'd1 ? {{16{lane_d[15] & !f3_q[2]}}, lane_d} : doutb;

  always_ff @(posedge clkb) begin
    if (rstb) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      lo_q        <= 2'd0;
      cnt_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      enb_q       <= 1'b0;
      web_q       <= 4'd0;
      addrb_q     <= 32'd0;
      dinb_q      <= 32'd0;
    end else begin
      enb_q <= 1'b0;
      web_q <= 4'd0;
      case (state_q)
        IDLE: if (accept) begin
          we_q <= req_we;
          f3_q <= req_funct3;
          lo_q <= req_addr[1:0];
          if (err_d) begin
            rsp_err_q <= 1'b1;
            state_q   <= RESP;
          end else begin
            enb_q   <= 1'b1;
            web_q   <= req_we ? web_d : 4'd0;
            addrb_q <= {req_addr[31:2], 2'b00};
            if (req_we) dinb_q <= dinb_d;
            state_q <= ISSUE;
          end
        end
        ISSUE: if (we_q) begin
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end else if (READ_LATENCY > 1) begin
          cnt_q   <= 2'(READ_LATENCY - 2);
          state_q <= WAIT;
        end else state_q <= CAPTURE;
        WAIT: if (cnt_q == 2'd0) state_q <= CAPTURE;
        else cnt_q <= cnt_q - 2'd1;
        CAPTURE: begin
          rsp_rdata_q <= rdata_d;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        // error responses enter RESP with valid low so they surface one edge after accept
        RESP: if (!rsp_valid_q) rsp_valid_q <= 1'b1;
        else if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'd0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign enb       = enb_q;
  assign web       = web_q;
  assign addrb     = addrb_q;
  assign dinb      = dinb_q;
endmodule

// File: tb/tb_bram_lsu_master.sv
// tb_bram_lsu_master: table, hand-written and random checks against a byte-array memory model
module tb_bram_lsu_master;
  localparam int MEM_DEPTH = 1096;
  localparam int RL = 1;
  localparam int NB = MEM_DEPTH * 4;

  logic clk = 1'b0, rstb = 1'b1, rstb3 = 1'b1, rstb_busy = 1'b0, rsp_ready = 1'b1;
  logic req_valid = 1'b0, req_valid3 = 1'b0, req_we = 1'b0;
  logic [2:0] req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic req_ready, rsp_valid, rsp_err, enb;
  logic [3:0] web;
  logic [31:0] rsp_rdata, addrb, dinb, doutb;
  logic req_ready3, rsp_valid3, rsp_err3, enb3;
  logic [3:0] web3;
  logic [31:0] rsp_rdata3, addrb3, dinb3, doutb3, p1, p2;
  logic [31:0] mem [MEM_DEPTH];
  logic [7:0] ref_mem [NB];
  logic [2:0] legal_ld [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  bram_lsu_master #(.MEM_DEPTH(MEM_DEPTH), .READ_LATENCY(RL)) u_dut (
    .clkb(clk), .rstb(rstb), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .enb(enb), .web(web),
    .addrb(addrb), .dinb(dinb), .doutb(doutb), .rstb_busy(rstb_busy));

  bram_lsu_master #(.MEM_DEPTH(MEM_DEPTH), .READ_LATENCY(3)) u_dut3 (
    .clkb(clk), .rstb(rstb3), .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .enb(enb3), .web(web3),
    .addrb(addrb3), .dinb(dinb3), .doutb(doutb3), .rstb_busy(rstb_busy));

  always @(posedge clk) begin : bram
    logic [31:0] w;
    int idx;
    if (enb) begin
      idx = int'(addrb[31:2]) % MEM_DEPTH;
      w = mem[idx];
      for (int b = 0; b < 4; b++) if (web[b]) w[8*b +: 8] = dinb[8*b +: 8];
      mem[idx] <= w;
      doutb <= mem[idx];
    end
  end

  always @(posedge clk) begin
    p1 <= enb3 ? 32'hA5A5_A5A5 : 32'h0;
    p2 <= p1;
    doutb3 <= p2;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic logic m_err(logic we, logic [2:0] f3, logic [31:0] a);
    logic legal = we ? f3 inside {3'd0, 3'd1, 3'd2} : f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    return !legal || (a % (32'd1 << f3[1:0]) != 0) || a >= 32'(NB);
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a);
    int n = 1 << f3[1:0];
    longint v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[int'(a) + i]) << (8 * i));
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output logic [3:0] ewb, output logic [31:0] edi);
    int n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    ewb = 4'(((1 << n) - 1) << (a % 4));
    for (int i = 0; i < 4; i++) edi[8*i +: 8] = wd[8*(i % n) +: 8];
  endtask

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat, output int en_n,
                      output logic [3:0] wb, output logic [31:0] di);
    logic ok = 1'b0;
    int t = 0;
    rd = 0; er = 0; lat = 0; en_n = 0; wb = 0; di = 0;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    #1;
    while (!ok && t < 20) begin
      ok = req_ready;
      step();
      t++;
    end
    req_valid = 1'b0;
    check("accepted", 32'(ok), 32'd1);
    if (!ok) return;
    t = 0;
    while (!rsp_valid && t < 20) begin
      if (enb) begin en_n++; wb = web; di = dinb; end
      step();
      t++;
    end
    lat = t; rd = rsp_rdata; er = rsp_err;
    step();
    check("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic wait_rsp(output logic [31:0] rd);
    int t = 0;
    while (!rsp_valid && t < 20) begin step(); t++; end
    check("rsp_seen", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
  endtask

  typedef struct {
    logic we; logic [2:0] f3; logic [31:0] addr, wdata, rdata; logic err; logic [3:0] web; logic [31:0] dinb;
  } vec_t;
  vec_t tab [16];

  initial begin
    logic [31:0] rd, di, exp_rd, edi;
    logic [3:0] wb, ewb;
    logic er;
    int lat, en_n, t;
    logic seen;
    tab[0]  = '{1'b1, 3'd2, 32'h0,    32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF};
    tab[1]  = '{1'b0, 3'd2, 32'h0,    32'h0,        32'hDEADBEEF, 1'b0, 4'b0000, 32'h0};
    tab[2]  = '{1'b1, 3'd0, 32'h5,    32'h000000EF, 32'h0,        1'b0, 4'b0010, 32'hEFEFEFEF};
    tab[3]  = '{1'b0, 3'd0, 32'h5,    32'h0,        32'hFFFFFFEF, 1'b0, 4'b0000, 32'h0};
    tab[4]  = '{1'b0, 3'd4, 32'h5,    32'h0,        32'h000000EF, 1'b0, 4'b0000, 32'h0};
    tab[5]  = '{1'b1, 3'd1, 32'h6,    32'h00008001, 32'h0,        1'b0, 4'b1100, 32'h80018001};
    tab[6]  = '{1'b0, 3'd1, 32'h6,    32'h0,        32'hFFFF8001, 1'b0, 4'b0000, 32'h0};
    tab[7]  = '{1'b0, 3'd5, 32'h6,    32'h0,        32'h00008001, 1'b0, 4'b0000, 32'h0};
    tab[8]  = '{1'b0, 3'd2, 32'h4,    32'h0,        32'h8001EF00, 1'b0, 4'b0000, 32'h0};
    tab[9]  = '{1'b0, 3'd0, 32'h1,    32'h0,        32'hFFFFFFBE, 1'b0, 4'b0000, 32'h0};
    tab[10] = '{1'b0, 3'd2, 32'h3,    32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
    tab[11] = '{1'b1, 3'd1, 32'h9,    32'h1234,     32'h0,        1'b1, 4'b0000, 32'h0};
    tab[12] = '{1'b0, 3'd2, 32'h1120, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
    tab[13] = '{1'b0, 3'd2, 32'h111C, 32'h0,        32'h0,        1'b0, 4'b0000, 32'h0};
    tab[14] = '{1'b0, 3'd3, 32'h0,    32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
    tab[15] = '{1'b1, 3'd4, 32'h0,    32'h55,       32'h0,        1'b1, 4'b0000, 32'h0};
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 32'h0;
    for (int i = 0; i < NB; i++) ref_mem[i] = 8'h0;

    req_valid = 1'b1;
    step(); step();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_enb", 32'(enb), 32'd0);
    check("rst_web", 32'(web), 32'd0);
    check("rst_addrb", addrb, 32'd0);
    check("rst_dinb", dinb, 32'd0);
    rstb = 1'b0; rstb3 = 1'b0; req_valid = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      xact(tab[i].we, tab[i].f3, tab[i].addr, tab[i].wdata, rd, er, lat, en_n, wb, di);
      check($sformatf("tab%0d_err", i), 32'(er), 32'(tab[i].err));
      check($sformatf("tab%0d_rdata", i), rd, tab[i].rdata);
      check($sformatf("tab%0d_lat", i), 32'(lat), (tab[i].we || tab[i].err) ? 32'd1 : 32'(1 + RL));
      check($sformatf("tab%0d_enb", i), 32'(en_n), tab[i].err ? 32'd0 : 32'd1);
      if (tab[i].we) check($sformatf("tab%0d_web", i), 32'(wb), 32'(tab[i].web));
      if (tab[i].we && !tab[i].err) begin
        check($sformatf("tab%0d_dinb", i), di, tab[i].dinb);
        m_store(tab[i].f3, tab[i].addr, tab[i].wdata, ewb, edi);
      end
    end

    // backpressure: response held while a new request waits
    rsp_ready = 1'b0;
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0; req_valid = 1'b1;
    #1;
    check("bp_ready", 32'(req_ready), 32'd1);
    step();
    req_funct3 = 3'd4; req_addr = 32'h5;
    wait_rsp(rd);
    exp_rd = m_load(3'd2, 32'h0);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, exp_rd);
      check("bp_ready_low", 32'(req_ready), 32'd0);
      check("bp_enb", 32'(enb), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp_ready_back", 32'(req_ready), 32'd1);
    step();
    check("bp_next_enb", 32'(enb), 32'd1);
    req_valid = 1'b0;
    wait_rsp(rd);
    check("bp_next_rdata", rd, m_load(3'd4, 32'h5));
    step();

    // BRAM busy blocks accept
    rstb_busy = 1'b1;
    req_funct3 = 3'd2; req_addr = 32'h4; req_valid = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("busy_ready", 32'(req_ready), 32'd0);
      check("busy_enb", 32'(enb), 32'd0);
      step();
    end
    rstb_busy = 1'b0;
    #1;
    check("busy_ready_back", 32'(req_ready), 32'd1);
    step();
    check("busy_enb_after", 32'(enb), 32'd1);
    req_valid = 1'b0;
    wait_rsp(rd);
    check("busy_rdata", rd, m_load(3'd2, 32'h4));
    step();

    // latency-3 instance: normal load, then reset while waiting
    req_funct3 = 3'd2; req_addr = 32'h0; req_valid3 = 1'b1;
    #1;
    check("l3_ready", 32'(req_ready3), 32'd1);
    step();
    req_valid3 = 1'b0;
    t = 0;
    while (!rsp_valid3 && t < 20) begin step(); t++; end
    check("l3_lat", 32'(t), 32'd4);
    check("l3_rdata", rsp_rdata3, 32'hA5A5A5A5);
    step();
    req_addr = 32'h10; req_valid3 = 1'b1;
    #1;
    step();
    req_valid3 = 1'b0;
    check("l3_enb", 32'(enb3), 32'd1);
    step();
    rstb3 = 1'b1;
    #1;
    check("l3_rst_ready", 32'(req_ready3), 32'd0);
    step();
    rstb3 = 1'b0; rstb_busy = 1'b1;
    check("l3_rst_enb", 32'(enb3), 32'd0);
    check("l3_rst_web", 32'(web3), 32'd0);
    check("l3_rst_addrb", addrb3, 32'd0);
    check("l3_rst_dinb", dinb3, 32'd0);
    check("l3_rst_rdata", rsp_rdata3, 32'd0);
    check("l3_rst_err", 32'(rsp_err3), 32'd0);
    #1;
    check("l3_busy_ready", 32'(req_ready3), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin seen = seen | rsp_valid3; step(); end
    check("l3_no_rsp", 32'(seen), 32'd0);
    rstb_busy = 1'b0;
    #1;
    check("l3_ready_back", 32'(req_ready3), 32'd1);

    for (int k = 0; k < 150; k++) begin
      logic we, ex_er;
      logic [2:0] f3;
      logic [31:0] a, wd;
      int n;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = we ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
      a = 32'($urandom_range(0, 31));
      case ($urandom_range(0, 9))
        0: a = 32'($urandom_range(NB - 8, NB + 7));
        1: a = $urandom;
        default: ;
      endcase
      n = 1 << f3[1:0];
      if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
      wd = $urandom;
      ex_er = m_err(we, f3, a);
      exp_rd = (we || ex_er) ? 32'd0 : m_load(f3, a);
      xact(we, f3, a, wd, rd, er, lat, en_n, wb, di);
      check("rnd_err", 32'(er), 32'(ex_er));
      check("rnd_rdata", rd, exp_rd);
      check("rnd_lat", 32'(lat), (we || ex_er) ? 32'd1 : 32'(1 + RL));
      check("rnd_enb", 32'(en_n), ex_er ? 32'd0 : 32'd1);
      if (we && !ex_er) begin
        m_store(f3, a, wd, ewb, edi);
        check("rnd_web", 32'(wb), 32'(ewb));
        check("rnd_dinb", di, edi);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
